// File: rtl/nes_bus_pkg.sv
// Shared types for the NES CPU-bus fabric: region tags, region base
// addresses, the OAM DMA state encoding and the address decoder.
package nes_bus_pkg;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_PPU,
    RGN_IO,
    RGN_CART
  } region_t;

  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] IO_BASE   = 16'h4000;
  localparam logic [15:0] CART_BASE = 16'h4020;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_ALIGN,
    DMA_ALIGN2,
    DMA_RD,
    DMA_WR
  } dma_state_t;

  // Top three address bits split RAM/PPU/high half; the $4000 page then
  // separates the 32 I/O registers from the cartridge space.
  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr < PPU_BASE) begin
      return RGN_RAM;
    end else if (addr < IO_BASE) begin
      return RGN_PPU;
    end else if (addr < CART_BASE) begin
      return RGN_IO;
    end
    return RGN_CART;
  endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA engine: copies one page from the memory bus into the PPU
// OAM data port, one byte per two CPU ticks, after a one- or two-tick
// alignment phase that depends on the parity of the triggering tick.
module nes_oam_dma import nes_bus_pkg::*; #(
  parameter int DMA_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        trig,
  input  logic [7:0]  trig_page,
  input  logic [7:0]  mem_din,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  ppu_dout,
  output logic        ppu_wreq
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state_reg, state_next;
  logic [7:0] page_reg, page_next;
  logic [7:0] idx_reg, idx_next;
  logic       odd_reg, odd_next;
  logic       parity_reg;

  // The source address is held through both RD and WR, so mem_din during WR
  // is the byte fetched for the current idx regardless of cpu_ce spacing.
  assign busy     = (state_reg != DMA_IDLE);
  assign mem_addr = {page_reg, idx_reg};
  assign ppu_dout = mem_din;

  // State, page/index registers and the free-running cpu_ce parity toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= DMA_IDLE;
      page_reg   <= 8'h00;
      idx_reg    <= 8'h00;
      odd_reg    <= 1'b0;
      parity_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      page_reg  <= page_next;
      idx_reg   <= idx_next;
      odd_reg   <= odd_next;
      if (cpu_ce) begin
        parity_reg <= ~parity_reg;
      end
    end
  end

  // Next-state logic; every transition other than the trigger waits for a tick.
  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    odd_next   = odd_reg;
    ppu_wreq   = 1'b0;
    case (state_reg)
      DMA_IDLE: begin
        if (trig) begin
          page_next  = trig_page;
          idx_next   = 8'h00;
          odd_next   = parity_reg;
          state_next = DMA_ALIGN;
        end
      end
      DMA_ALIGN: begin
        if (cpu_ce) begin
          state_next = odd_reg ? DMA_ALIGN2 : DMA_RD;
        end
      end
      DMA_ALIGN2: begin
        if (cpu_ce) begin
          state_next = DMA_RD;
        end
      end
      DMA_RD: begin
        if (cpu_ce) begin
          state_next = DMA_WR;
        end
      end
      DMA_WR: begin
        ppu_wreq = cpu_ce;
        if (cpu_ce) begin
          if (idx_reg == LAST_IDX) begin
            idx_next = 8'h00;
            // A trigger landing on the final tick restarts immediately.
            if (trig) begin
              page_next  = trig_page;
              odd_next   = parity_reg;
              state_next = DMA_ALIGN;
            end else begin
              state_next = DMA_IDLE;
            end
          end else begin
            idx_next   = idx_reg + 8'd1;
            state_next = DMA_RD;
          end
        end
      end
      default: state_next = DMA_IDLE;
    endcase
  end

endmodule

// File: rtl/nes_bus_dma.sv
// NES CPU-bus fabric: decodes the 6502 address space onto RAM, PPU, I/O and
// cartridge ports and muxes read data back to the CPU. Define NES_OAM_DMA_EN
// to include the $4014 sprite DMA engine; without it $4014 is a plain I/O
// register and cpu_rdy is constant 1.
module nes_bus_dma import nes_bus_pkg::*; #(
  parameter int                 RAM_AW  = 11,
  parameter int                 PPU_AW  = 3,
  parameter logic [15:0]        DMA_REG = 16'h4014,
  parameter logic [PPU_AW-1:0]  OAM_REG = 3'd4,
  parameter int                 DMA_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ce,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wreq,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_din,
  output logic              cpu_rdy,
  output logic [15:0]       mem_addr,
  output logic [7:0]        mem_dout,
  output logic              mem_wreq,
  input  logic [7:0]        mem_din,
  output logic [PPU_AW-1:0] ppu_sel,
  output logic [7:0]        ppu_dout,
  output logic              ppu_wreq,
  output logic              ppu_rd,
  input  logic [7:0]        ppu_din,
  output logic [4:0]        io_addr,
  output logic              io_wreq,
  input  logic [7:0]        io_din
);

  localparam logic [15:0] RAM_MASK = 16'((32'd1 << RAM_AW) - 32'd1);

  region_t     rgn;
  region_t     tag_reg;
  logic        din_en_reg;
  logic        dma_trap;
  logic        cpu_go;
  logic        dma_busy;
  logic [15:0] dma_mem_addr;
  logic [7:0]  dma_ppu_dout;
  logic        dma_ppu_wreq;

`ifdef NES_OAM_DMA_EN
  assign dma_trap = (cpu_addr == DMA_REG);

  nes_oam_dma #(
    .DMA_LEN (DMA_LEN)
  ) u_dma (
    .clk       (clk),
    .reset     (reset),
    .cpu_ce    (cpu_ce),
    .trig      (cpu_ce & cpu_wreq & dma_trap),
    .trig_page (cpu_dout),
    .mem_din   (mem_din),
    .busy      (dma_busy),
    .mem_addr  (dma_mem_addr),
    .ppu_dout  (dma_ppu_dout),
    .ppu_wreq  (dma_ppu_wreq)
  );
`else
  assign dma_trap     = 1'b0;
  assign dma_busy     = 1'b0;
  assign dma_mem_addr = 16'h0000;
  assign dma_ppu_dout = 8'h00;
  assign dma_ppu_wreq = 1'b0;
`endif

  assign cpu_rdy = ~dma_busy;
  assign rgn     = decode_region(cpu_addr);
  assign cpu_go  = cpu_ce & cpu_rdy & ~dma_trap;

  // Region decode and strobe qualification; DMA takes every bus while busy.
  always_comb begin
    mem_addr = 16'h0000;
    mem_dout = cpu_dout;
    mem_wreq = 1'b0;
    ppu_sel  = '0;
    ppu_dout = cpu_dout;
    ppu_wreq = 1'b0;
    ppu_rd   = 1'b0;
    io_addr  = 5'h00;
    io_wreq  = 1'b0;
    if (dma_busy) begin
      mem_addr = dma_mem_addr;
      ppu_sel  = OAM_REG;
      ppu_dout = dma_ppu_dout;
      ppu_wreq = dma_ppu_wreq;
    end else begin
      case (rgn)
        RGN_RAM: begin
          mem_addr = cpu_addr & RAM_MASK;
          mem_wreq = cpu_wreq & cpu_go;
        end
        RGN_CART: begin
          mem_addr = cpu_addr;
          mem_wreq = cpu_wreq & cpu_go;
        end
        RGN_PPU: begin
          ppu_sel  = cpu_addr[PPU_AW-1:0];
          ppu_wreq = cpu_wreq & cpu_go;
          ppu_rd   = cpu_rd & cpu_go;
        end
        default: begin
          io_addr = cpu_addr[4:0];
          io_wreq = cpu_wreq & cpu_go;
        end
      endcase
    end
  end

  // Region tag follows the address by one clk to line up with SRAM latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_reg    <= RGN_RAM;
      din_en_reg <= 1'b0;
    end else begin
      tag_reg    <= dma_busy ? RGN_RAM : rgn;
      din_en_reg <= 1'b1;
    end
  end

  // Read-data return mux, held at zero until the first clk after reset.
  always_comb begin
    cpu_din = 8'h00;
    if (din_en_reg) begin
      case (tag_reg)
        RGN_PPU: cpu_din = ppu_din;
        RGN_IO:  cpu_din = io_din;
        default: cpu_din = mem_din;
      endcase
    end
  end

endmodule

// File: doc/nes_bus_dma.md
# nes_bus_dma

Parametrised CPU-bus fabric for the NES core. It decodes the 6502 address space into internal RAM, PPU registers, I/O and cartridge regions, and returns read data to the CPU from the selected source. It also contains the sprite OAM DMA engine at $4014, which stalls the CPU and copies one 256-byte page into PPU port $2004. It sits between `cpu`, `ppu` and the synchronous SRAM arrays in the top level.

## Interface
Parameters:
- RAM_AW, 11: internal RAM address width. $0000–$1FFF is mirrored onto 2^RAM_AW bytes.
- PPU_AW, 3: PPU register select width. $2000–$3FFF is mirrored onto 2^PPU_AW registers.
- DMA_REG, 16'h4014: address of the DMA trigger register.
- OAM_REG, 3'd4: PPU register that DMA writes to.
- DMA_LEN, 256: bytes per DMA transfer.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- cpu_ce, in, 1: CPU clock-enable tick (cpuclk), one clk wide.
- cpu_addr, in, 16: CPU address.
- cpu_dout, in, 8: CPU write data.
- cpu_wreq, in, 1: CPU write strobe.
- cpu_rd, in, 1: CPU read strobe.
- cpu_din, out, 8: read data returned to the CPU.
- cpu_rdy, out, 1: low while DMA owns the bus. The CPU holds its state while this is low.
- mem_addr, out, 16: SRAM address. Mirrored for RAM; raw for the cartridge region.
- mem_dout, out, 8: SRAM write data.
- mem_wreq, out, 1: SRAM write strobe.
- mem_din, in, 8: SRAM read data, valid one clk after mem_addr.
- ppu_sel, out, PPU_AW: PPU register index.
- ppu_dout, out, 8: PPU write data.
- ppu_wreq, out, 1: PPU register write strobe.
- ppu_rd, out, 1: PPU register read strobe.
- ppu_din, in, 8: PPU read data.
- io_addr, out, 5: I/O offset within $4000–$401F.
- io_wreq, out, 1: I/O write strobe.
- io_din, in, 8: I/O read data.

## Operation
- Address decode from the top three address bits plus the $4000 page:
  - RAM: $0000–$1FFF.
  - PPU: $2000–$3FFF.
  - IO: $4000–$401F.
  - CART: $4020–$FFFF. CART and RAM both go to mem_*.
- cpu_din mux:
  - Selected by a region tag registered on the same clk as the address, so it lines up with the 1-clk SRAM latency.
  - PPU tag selects ppu_din, IO tag selects io_din, otherwise mem_din.
- Strobes are qualified by cpu_ce and cpu_rdy:
  - mem_wreq/ppu_wreq/io_wreq = cpu_wreq & cpu_ce & region hit.
  - ppu_rd = cpu_rd & cpu_ce & PPU hit.
- DMA state machine:
  - States: IDLE → ALIGN → (ALIGN2 if odd) → RD → WR → RD … → IDLE.
  - IDLE: a CPU write to DMA_REG latches page = cpu_dout and enters ALIGN. cpu_rdy drops on the next clk.
  - ALIGN: one cpu_ce tick. If the internal cpu_ce parity toggle is odd, one more tick is spent in ALIGN2.
  - RD: drive mem_addr = {page, idx}, then wait for a cpu_ce tick.
  - WR: ppu_sel = OAM_REG, ppu_dout = the mem_din captured in RD, ppu_wreq for one cpu_ce tick. Then idx+1.
  - When idx wraps from DMA_LEN-1, go to IDLE and set cpu_rdy=1.
- idx is an 8-bit counter. Page $FF is legal; the copy reads $FF00–$FFFF.
- During DMA, CPU strobes are ignored and all buses are owned by DMA.

## Timing
- Reset values: cpu_rdy=1, all strobes 0, mem_addr/ppu_sel/io_addr=0, cpu_din=0, state IDLE, parity 0.
- CPU read latency is 1 clk after the address for every region.
- DMA takes 1+(odd)+2·DMA_LEN cpu_ce ticks, i.e. 513 or 514 for 256 bytes. cpu_rdy is low for exactly that window.
- Reset asserted mid-DMA aborts the transfer immediately, with no further ppu_wreq, and restores reset values.
- A CPU write to DMA_REG on the same tick that DMA finishes is taken as a new trigger.
- cpu_ce gaps of any length are tolerated: the state advances only on ticks.

## Configuration
- NES_OAM_DMA_EN defined: DMA engine present as described.
- NES_OAM_DMA_EN not defined:
  - DMA_REG is treated as a plain IO write (io_wreq, io_addr=5'h14).
  - cpu_rdy is tied to 1 and no DMA logic is generated.

## Structure
- Package nes_bus_pkg holds:
  - Region enum (RGN_RAM, RGN_PPU, RGN_IO, RGN_CART).
  - Base-address constants $2000/$4000/$4020.
  - DMA state enum.
- One sub-module, nes_oam_dma: holds the state machine, page/idx registers and parity toggle. It outputs a bus-override request plus address/data/strobes. The top performs decode and muxing.

## Test plan
- Read $0801 with RAM byte $0001=$5A → mem_addr=$0001, cpu_din=$5A one clk later.
- Write $3FF9 with data $1E → ppu_sel=1, ppu_wreq for one clk. A read of $2002 returns ppu_din.
- Write $4014 with $02 on an even tick, RAM $0200+i = i^$A5 → 256 ppu_wreq to sel 4 with data i^$A5 in order, cpu_rdy low for 513 ticks.
- Same trigger on an odd tick → cpu_rdy low for 514 ticks, data identical.
- Assert reset at byte 100 of a DMA → cpu_rdy=1 immediately, no further ppu_wreq. A fresh trigger after release completes normally.
- NES_OAM_DMA_EN undefined: write $4014 with $02 → io_wreq with io_addr=$14, cpu_rdy stays 1.
